// File: rtl/hazard_unit.sv
// Pipeline hazard tracker: shadows the EXE/MEM/WB occupants and decides the ID stall,
// the ID/EX bubble, the IF/ID flush and, in forwarding builds, the EXE operand selects.
module hazard_unit #(
  parameter bit FORWARD_EN = 1'b0,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r,
  input  logic              exe_br_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush_if_id,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // Producer view of a slot; MEM and WB only ever act as producers.
  typedef struct packed {
    logic              v;
    logic              wb;
    logic [REG_AW-1:0] dest;
  } prod_t;

  typedef struct packed {
    prod_t             p;
    logic              mem_r;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              src2_used;
  } exe_slot_t;

  exe_slot_t exe_q, exe_d;
  prod_t     mem_q, mem_d;
  prod_t     wb_q, wb_d;

  logic       hit_exe, hit_mem, hit_wb;
  logic       raw_hazard;
  logic [1:0] sel_a, sel_b;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic hits(input prod_t p, input logic [REG_AW-1:0] r);
    return p.v && p.wb && (p.dest == r) && (r != '0);
  endfunction

  // The youngest producer (MEM) wins over the older one (WB).
  function automatic logic [1:0] fwd_sel(input prod_t m, input prod_t w,
                                         input logic [REG_AW-1:0] r);
    if (hits(m, r))      return 2'd1;
    else if (hits(w, r)) return 2'd2;
    else                 return 2'd0;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit_exe    = hits(exe_q.p, id_src1) || (id_src2_used && hits(exe_q.p, id_src2));
    hit_mem    = hits(mem_q, id_src1)   || (id_src2_used && hits(mem_q, id_src2));
    hit_wb     = hits(wb_q, id_src1)    || (id_src2_used && hits(wb_q, id_src2));
    raw_hazard = id_valid && !exe_br_taken &&
                 (FORWARD_EN ? (hit_exe && exe_q.mem_r) : (hit_exe || hit_mem || hit_wb));

    stall       = raw_hazard;
    bubble      = raw_hazard || exe_br_taken;
    flush_if_id = exe_br_taken;

    sel_a = fwd_sel(mem_q, wb_q, exe_q.src1);
    sel_b = exe_q.src2_used ? fwd_sel(mem_q, wb_q, exe_q.src2) : 2'd0;
    fwd_a = FORWARD_EN ? sel_a : 2'd0;
    fwd_b = FORWARD_EN ? sel_b : 2'd0;
  end

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = exe_q.p;
      if (bubble) begin
        exe_d = '0;
      end else begin
        exe_d.p.v       = id_valid;
        exe_d.p.wb      = id_wb_en;
        exe_d.p.dest    = id_dest;
        exe_d.mem_r     = id_mem_r;
        exe_d.src1      = id_src1;
        exe_d.src2      = id_src2;
        exe_d.src2_used = id_src2_used;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all slots shift on the same edge.
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a stall-only and a forwarding instance, each driven
// with directed instruction streams; expected outputs are queued at drive time and checked later.
module tb_hazard_unit;

  localparam int AW = 5;

  typedef struct packed {
    logic          rst;
    logic          hold;
    logic          id_valid;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic          src2_used;
    logic [AW-1:0] dest;
    logic          wb_en;
    logic          mem_r;
    logic          br;
  } drv_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } obs_t;

  typedef struct {
    bit    fw;
    obs_t  exp;
    string tag;
  } sb_t;

  localparam drv_t IDLE = '0;
  localparam obs_t ZERO = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  drv_t in_nf = IDLE;
  drv_t in_fw = IDLE;
  obs_t out_nf, out_fw;
  logic stall_nf, bubble_nf, flush_nf, stall_fw, bubble_fw, flush_fw;
  logic [1:0] fa_nf, fb_nf, fa_fw, fb_fw;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  hazard_unit #(.FORWARD_EN(1'b0), .REG_AW(AW)) u_nf (
    .clk(clk), .rst(in_nf.rst), .hold(in_nf.hold), .id_valid(in_nf.id_valid),
    .id_src1(in_nf.src1), .id_src2(in_nf.src2), .id_src2_used(in_nf.src2_used),
    .id_dest(in_nf.dest), .id_wb_en(in_nf.wb_en), .id_mem_r(in_nf.mem_r),
    .exe_br_taken(in_nf.br), .stall(stall_nf), .bubble(bubble_nf),
    .flush_if_id(flush_nf), .fwd_a(fa_nf), .fwd_b(fb_nf)
  );

  hazard_unit #(.FORWARD_EN(1'b1), .REG_AW(AW)) u_fw (
    .clk(clk), .rst(in_fw.rst), .hold(in_fw.hold), .id_valid(in_fw.id_valid),
    .id_src1(in_fw.src1), .id_src2(in_fw.src2), .id_src2_used(in_fw.src2_used),
    .id_dest(in_fw.dest), .id_wb_en(in_fw.wb_en), .id_mem_r(in_fw.mem_r),
    .exe_br_taken(in_fw.br), .stall(stall_fw), .bubble(bubble_fw),
    .flush_if_id(flush_fw), .fwd_a(fa_fw), .fwd_b(fb_fw)
  );

  assign out_nf = {stall_nf, bubble_nf, flush_nf, fa_nf, fb_nf};
  assign out_fw = {stall_fw, bubble_fw, flush_fw, fa_fw, fb_fw};

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic drv_t ins(input logic [AW-1:0] dest, input logic [AW-1:0] s1,
                               input logic [AW-1:0] s2, input logic s2u,
                               input logic wb, input logic ld);
    drv_t d = '0;
    d.id_valid  = 1'b1;
    d.dest      = dest;
    d.src1      = s1;
    d.src2      = s2;
    d.src2_used = s2u;
    d.wb_en     = wb;
    d.mem_r     = ld;
    return d;
  endfunction

  function automatic obs_t ex(input logic st, input logic bu, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb);
    obs_t o;
    o.stall  = st;
    o.bubble = bu;
    o.flush  = fl;
    o.fwd_a  = fa;
    o.fwd_b  = fb;
    return o;
  endfunction

  function automatic drv_t with_hold(input drv_t d);
    drv_t r = d;
    r.hold = 1'b1;
    return r;
  endfunction

  function automatic drv_t with_rst(input drv_t d);
    drv_t r = d;
    r.rst = 1'b1;
    return r;
  endfunction

  function automatic drv_t with_br(input drv_t d);
    drv_t r = d;
    r.br = 1'b1;
    return r;
  endfunction

  // Drive one cycle of ID/EXE inputs into the selected instance and queue its expected outputs.
  task automatic step(input bit fw, input drv_t d, input obs_t x, input string tag);
    if (fw) begin
      in_fw = d;
      in_nf = IDLE;
    end else begin
      in_nf = d;
      in_fw = IDLE;
    end
    sb.push_back('{fw: fw, exp: x, tag: tag});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit fw, input string tag);
    for (int i = 0; i < 3; i++) step(fw, IDLE, ZERO, $sformatf("%s.idle%0d", tag, i));
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t  e;
      obs_t o;
      e = sb.pop_front();
      o = e.fw ? out_fw : out_nf;
      check({e.tag, ".stall"},  {1'b0, o.stall},  {1'b0, e.exp.stall});
      check({e.tag, ".bubble"}, {1'b0, o.bubble}, {1'b0, e.exp.bubble});
      check({e.tag, ".flush"},  {1'b0, o.flush},  {1'b0, e.exp.flush});
      check({e.tag, ".fwd_a"},  o.fwd_a,          e.exp.fwd_a);
      check({e.tag, ".fwd_b"},  o.fwd_b,          e.exp.fwd_b);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drv_t add_r3, sub_r4;
    add_r3 = ins(3, 1, 2, 1'b1, 1'b1, 1'b0);
    sub_r4 = ins(4, 3, 1, 1'b1, 1'b1, 1'b0);

    in_nf = with_rst(IDLE);
    in_fw = with_rst(IDLE);
    repeat (2) @(posedge clk);
    #1;

    // Reset state on both builds.
    drain(1'b0, "rst_nf");
    drain(1'b1, "rst_fw");

    // Stall-only RAW: three stall cycles, consumer enters EXE on the 4th edge.
    step(1'b0, add_r3, ZERO,                     "raw_nf.c0");
    step(1'b0, sub_r4, ex(1, 1, 0, 0, 0),        "raw_nf.c1");
    step(1'b0, sub_r4, ex(1, 1, 0, 0, 0),        "raw_nf.c2");
    step(1'b0, sub_r4, ex(1, 1, 0, 0, 0),        "raw_nf.c3");
    step(1'b0, sub_r4, ZERO,                     "raw_nf.c4");
    step(1'b0, ins(9, 4, 0, 1'b0, 1'b1, 1'b0), ex(1, 1, 0, 0, 0), "raw_nf.sub_in_exe");
    drain(1'b0, "raw_nf");

    // Unused src2 never stalls; used src2 does.
    step(1'b0, add_r3, ZERO,                                      "s2u_nf.c0");
    step(1'b0, ins(4, 1, 3, 1'b0, 1'b1, 1'b0), ZERO,              "s2u_nf.unused");
    step(1'b0, ins(4, 1, 3, 1'b1, 1'b1, 1'b0), ex(1, 1, 0, 0, 0), "s2u_nf.used");
    drain(1'b0, "s2u_nf");

    // Hold for two cycles mid-stall: slots freeze, three stall cycles outside hold.
    step(1'b0, add_r3,            ZERO,              "hold_nf.c0");
    step(1'b0, sub_r4,            ex(1, 1, 0, 0, 0), "hold_nf.c1");
    step(1'b0, with_hold(sub_r4), ex(1, 1, 0, 0, 0), "hold_nf.h0");
    step(1'b0, with_hold(sub_r4), ex(1, 1, 0, 0, 0), "hold_nf.h1");
    step(1'b0, sub_r4,            ex(1, 1, 0, 0, 0), "hold_nf.c2");
    step(1'b0, sub_r4,            ex(1, 1, 0, 0, 0), "hold_nf.c3");
    step(1'b0, sub_r4,            ZERO,              "hold_nf.c4");
    drain(1'b0, "hold_nf");

    // Reset mid-stall clears the slots on that edge.
    step(1'b0, add_r3,           ZERO,              "rst_mid.c0");
    step(1'b0, sub_r4,           ex(1, 1, 0, 0, 0), "rst_mid.c1");
    step(1'b0, with_rst(sub_r4), ex(1, 1, 0, 0, 0), "rst_mid.rst");
    step(1'b0, sub_r4,           ZERO,              "rst_mid.after");
    drain(1'b0, "rst_mid");

    // Taken branch beats a RAW on EXE; the discarded instruction must not occupy EXE.
    step(1'b0, add_r3, ZERO, "br_nf.c0");
    step(1'b0, with_br(ins(6, 3, 1, 1'b1, 1'b1, 1'b0)), ex(0, 1, 1, 0, 0), "br_nf.taken");
    step(1'b0, ins(12, 6, 0, 1'b0, 1'b1, 1'b0), ZERO, "br_nf.next");
    drain(1'b0, "br_nf");

    step(1'b1, ins(5, 1, 0, 1'b0, 1'b1, 1'b1), ZERO, "br_fw.c0");
    step(1'b1, with_br(ins(6, 5, 0, 1'b0, 1'b1, 1'b1)), ex(0, 1, 1, 0, 0), "br_fw.taken");
    step(1'b1, ins(13, 6, 0, 1'b1, 1'b1, 1'b0), ZERO, "br_fw.next");
    drain(1'b1, "br_fw");

    // Register 0 as destination/source: no stall, no forward in either build.
    step(1'b0, ins(0, 1, 0, 1'b0, 1'b1, 1'b0), ZERO, "r0_nf.c0");
    step(1'b0, ins(8, 0, 0, 1'b1, 1'b1, 1'b0), ZERO, "r0_nf.c1");
    step(1'b0, IDLE,                           ZERO, "r0_nf.c2");
    drain(1'b0, "r0_nf");
    step(1'b1, ins(0, 1, 0, 1'b0, 1'b1, 1'b0), ZERO, "r0_fw.c0");
    step(1'b1, ins(8, 0, 0, 1'b1, 1'b1, 1'b0), ZERO, "r0_fw.c1");
    step(1'b1, IDLE,                           ZERO, "r0_fw.c2");
    drain(1'b1, "r0_fw");

    // Load-use with forwarding: one stall, then both operands come from WB.
    step(1'b1, ins(5, 1, 0, 1'b0, 1'b1, 1'b1), ZERO,              "ldu_fw.c0");
    step(1'b1, ins(6, 5, 5, 1'b1, 1'b1, 1'b0), ex(1, 1, 0, 0, 0), "ldu_fw.c1");
    step(1'b1, ins(6, 5, 5, 1'b1, 1'b1, 1'b0), ZERO,              "ldu_fw.c2");
    step(1'b1, IDLE,                           ex(0, 0, 0, 2, 2), "ldu_fw.exe");
    drain(1'b1, "ldu_fw");

    // Two producers of r2: MEM beats WB; r0 operand is never forwarded.
    step(1'b1, ins(2, 1, 1, 1'b1, 1'b1, 1'b0), ZERO,              "prio_fw.c0");
    step(1'b1, ins(2, 1, 1, 1'b1, 1'b1, 1'b0), ZERO,              "prio_fw.c1");
    step(1'b1, ins(7, 2, 0, 1'b1, 1'b1, 1'b0), ZERO,              "prio_fw.c2");
    step(1'b1, IDLE,                           ex(0, 0, 0, 1, 0), "prio_fw.exe");
    drain(1'b1, "prio_fw");

    // fwd_b honours src2_used and picks WB when MEM does not match.
    step(1'b1, ins(9, 1, 1, 1'b1, 1'b1, 1'b0),  ZERO,              "fwdb_fw.c0");
    step(1'b1, ins(10, 1, 9, 1'b0, 1'b1, 1'b0), ZERO,              "fwdb_fw.c1");
    step(1'b1, ins(11, 1, 9, 1'b1, 1'b1, 1'b0), ZERO,              "fwdb_fw.unused");
    step(1'b1, IDLE,                            ex(0, 0, 0, 0, 2), "fwdb_fw.wb");
    drain(1'b1, "fwdb_fw");

    check("sb_drained", {1'b0, sb.size() == 0}, 2'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
